// File: rtl/aes_iter_pkg.sv
// Shared types, constants and GF(2^8)/AES helper functions for the iterative AES core.
package aes_iter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [3:0] NR_128   = 4'd10;
  localparam logic [3:0] NR_256   = 4'd14;
  localparam logic       MODE_128 = 1'b0;
  localparam logic       MODE_256 = 1'b1;

  // Round-constant table, indexed from 0 (Rcon[1] in FIPS-197 numbering).
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0]  x2, x3, x12, x15, x240, inv;
    logic [15:0] d;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    d    = {inv, inv};
    return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One cipher round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
  // Byte i = row + 4*column sits at bits [127-8i -: 8].
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r[119-32*c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r[111-32*c -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r[103-32*c -: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return r ^ rk;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One on-the-fly key-expansion step. AES-128 advances the upper four words in place;
// AES-256 slides an eight-word window and appends four new words (type A or type B).
module aes_key_step
  import aes_iter_pkg::*;
(
  input  logic         mode_i,
  input  logic         step_b_i,
  input  logic [7:0]   rcon_i,
  input  logic [255:0] key_i,
  output logic [255:0] key_o
);

  logic [31:0] w_last;
  logic [31:0] g;
  logic [31:0] n0, n1, n2, n3;

  // Word recurrence w[i] = w[i-Nk] ^ f(w[i-1]) over the active window.
  always_comb begin
    w_last = (mode_i == MODE_256) ? key_i[31:0] : key_i[159:128];
    if (step_b_i) g = sub_word(w_last);
    else          g = sub_word({w_last[23:0], w_last[31:24]}) ^ {rcon_i, 24'h0};
    n0    = key_i[255:224] ^ g;
    n1    = key_i[223:192] ^ n0;
    n2    = key_i[191:160] ^ n1;
    n3    = key_i[159:128] ^ n2;
    key_o = (mode_i == MODE_256) ? {key_i[127:0], n0, n1, n2, n3}
                                 : {n0, n1, n2, n3, key_i[127:0]};
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core: one shared round datapath, two cycles per round
// (key step, then round), valid/ready handshakes and a sideband tag.
// Optional macro AES_ITER_ABORT_EN adds an abort input that cancels a block in RUN.
module aes_iter_core
  import aes_iter_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [127:0]     in_state,
  input  logic [255:0]     in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef AES_ITER_ABORT_EN
  ,
  input  logic             abort
`endif
);

  state_e             state_q, state_d;
  logic [127:0]       s_q, s_d;
  logic [255:0]       k_q, k_d;
  logic               mode_q, mode_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [3:0]         rnd_q, rnd_d;
  logic               ph_q, ph_d;
  logic [127:0]       out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic [3:0]   nr;
  logic [3:0]   rcon_idx;
  logic [255:0] key_next;
  logic [127:0] round_key;
  logic [127:0] round_out;
  logic         abort_w;

`ifdef AES_ITER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign nr        = (mode_q == MODE_256) ? NR_256 : NR_128;
  assign rcon_idx  = (mode_q == MODE_256) ? {1'b0, rnd_q[3:1]} : rnd_q;
  assign round_key = (mode_q == MODE_256) ? k_q[127:0] : k_q[255:128];
  assign round_out = aes_round(s_q, round_key, rnd_q == nr - 4'd1);

  aes_key_step u_key_step (
    .mode_i   (mode_q),
    .step_b_i (mode_q & ~rnd_q[0]),
    .rcon_i   (rcon(rcon_idx)),
    .key_i    (k_q),
    .key_o    (key_next)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    s_d        = s_q;
    k_d        = k_q;
    mode_d     = mode_q;
    tag_d      = tag_q;
    rnd_d      = rnd_q;
    ph_d       = ph_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_state ^ in_key[255:128];
          k_d     = in_key;
          mode_d  = (MAX_KEY_BITS == 256) ? in_mode : MODE_128;
          tag_d   = in_tag;
          rnd_d   = '0;
          ph_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_w) begin
          rnd_d   = '0;
          ph_d    = 1'b0;
          state_d = IDLE;
        end else if (rnd_q == nr) begin
          out_data_d = s_q;
          out_tag_d  = tag_q;
          rnd_d      = '0;
          state_d    = DONE;
        end else if (!ph_q) begin
          // AES-256 round 0 uses the second key half as loaded, so no step is taken.
          if (!(mode_q == MODE_256 && rnd_q == 4'd0)) k_d = key_next;
          ph_d = 1'b1;
        end else begin
          s_d   = round_out;
          rnd_d = rnd_q + 4'd1;
          ph_d  = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so no X ever reaches out_data or the rounds.
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      k_q        <= '0;
      mode_q     <= MODE_128;
      tag_q      <= '0;
      rnd_q      <= '0;
      ph_q       <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q    <= state_d;
      s_q        <= s_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      tag_q      <= tag_d;
      rnd_q      <= rnd_d;
      ph_q       <= ph_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: FIPS-197 / SP800-38A vectors, latency,
// backpressure, back-to-back mixed modes, reset mid-block and (optionally) abort.
module tb_aes_iter_core;

  localparam int TAG_W = 4;

  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef_cafef00d_12345678_9abcdef0};
  localparam logic [127:0] CT128_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K128_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT128_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_E    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [255:0] K256_E  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] CT256_E = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [127:0]     in_state = '0;
  logic [255:0]     in_key = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef AES_ITER_ABORT_EN
  logic             abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct packed {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  aes_iter_core #(.MAX_KEY_BITS(256), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef AES_ITER_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every output handshake is matched against the oldest expected block.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got out_data=%h tag=%h, required no output", out_data, out_tag);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_tag !== mon_e.tag) begin
          n_err++;
          $display("FAIL sb_output: got data=%h tag=%h, required data=%h tag=%h",
                   out_data, out_tag, mon_e.data, mon_e.tag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block, wait (bounded) for in_ready, accept on the next edge.
  task automatic send(input logic mode, input logic [127:0] pt, input logic [255:0] key,
                      input logic [TAG_W-1:0] tag, input logic [127:0] exp_ct);
    int guard = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_state = pt;
    in_key   = key;
    in_tag   = tag;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{data: exp_ct, tag: tag});
      tick();
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_tag   = TAG_W'($urandom);
    end
  endtask

  // Wait (bounded) for out_valid and compare the accept-to-valid latency.
  task automatic wait_out(input int exp_lat, input string name);
    int guard = 0;
    while (!out_valid && guard < 100) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (!out_valid || (cyc - acc_cyc) !== exp_lat) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles (out_valid=%b), required %0d",
               name, cyc - acc_cyc, out_valid, exp_lat);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flags: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    n_cmp++;
    if (out_data !== 128'h0 || out_tag !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h tag=%h, required 0/0", out_data, out_tag);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_vector(input logic mode, input logic [127:0] pt, input logic [255:0] key,
                             input logic [TAG_W-1:0] tag, input logic [127:0] ct,
                             input int lat, input string name);
    out_ready = 1'b0;
    send(mode, pt, key, tag, ct);
    wait_out(lat, name);
    n_cmp++;
    if (out_data !== ct || out_tag !== tag) begin
      n_err++;
      $display("FAIL %s_data: got %h/%h, required %h/%h", name, out_data, out_tag, ct, tag);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_release: got out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int seen = 0;
    out_ready = 1'b0;
    send(1'b0, PT_B, K128_B, 4'hA, CT128_B);
    wait_out(21, "bp");
    // Competing block offered while the result is held.
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_state = PT_E;
    in_key   = K256_E;
    in_tag   = 4'h1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== CT128_B || out_tag !== 4'hA) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b data=%h tag=%h, required 1/0/%h/a",
                 i, out_valid, in_ready, out_data, out_tag, CT128_B);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 35; i++) begin
      tick();
      if (out_valid || !in_ready) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL bp_no_accept: got %0d busy cycles, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(1'b1, PT_E, K256_E, 4'h5, CT256_E);
    send(1'b0, PT_C, K128_C1, 4'h9, CT128_C1);
    wait_out(21, "b2b");
    tick();
    n_cmp++;
    if (sb.size() !== 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d pending, out_valid=%b, required 0/0", sb.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1;
    send(1'b1, PT_C, K256_C3, 4'hC, CT256_C3);
    for (int i = 0; i < 11; i++) begin
      tick();
      if (out_valid) seen++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0) begin
      n_err++;
      $display("FAIL rstmid_async: got rdy=%b v=%b data=%h, required 1/0/0", in_ready, out_valid, out_data);
    end
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_ready: got in_ready=%b, required 1", in_ready);
    end
    for (int i = 0; i < 35; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL rstmid_no_valid: got %0d valid cycles, required 0", seen);
    end
    test_vector(1'b0, PT_C, K128_C1, 4'h6, CT128_C1, 21, "rstmid_next");
  endtask

`ifdef AES_ITER_ABORT_EN
  task automatic test_abort();
    int seen = 0;
    out_ready = 1'b0;
    send(1'b1, PT_C, K256_C3, 4'h2, CT256_C3);
    for (int i = 0; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_run: got rdy=%b v=%b, required 1/0", in_ready, out_valid);
    end
    sb.delete();
    for (int i = 0; i < 35; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_no_valid: got %0d valid cycles, required 0", seen);
    end
    send(1'b0, PT_C, K128_C1, 4'h7, CT128_C1);
    wait_out(21, "abort_done");
    abort = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== CT128_C1) begin
      n_err++;
      $display("FAIL abort_in_done: got v=%b data=%h, required 1/%h", out_valid, out_data, CT128_C1);
    end
    abort     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_vector(1'b0, PT_C, K128_C1, 4'h3, CT128_C1, 21, "aes128_c1");
    test_vector(1'b1, PT_C, K256_C3, 4'h4, CT256_C3, 29, "aes256_c3");
    test_vector(1'b1, PT_E, K256_E, 4'hE, CT256_E, 29, "aes256_sp");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_ITER_ABORT_EN
    test_abort();
`endif
    tick();
    tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending blocks, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
